restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 13 +
 rtl/restoring_divider_div_step.sv | 24 ++
 rtl/restoring_divider.sv | 150 +++++++++++++++
 tb/tb_restoring_divider.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared types and default widths for the restoring divider.
package restoring_divider_pkg;

    localparam int DEF_DVD_W = 8;
    localparam int DEF_DVS_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : restoring_divider_pkg

// File: rtl/restoring_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int DVS_W = 4
) (
    input  logic [DVS_W:0]   rem_i,
    input  logic             bit_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVS_W:0]   rem_o,
    output logic             q_o
);

    logic [DVS_W+1:0] trial;
    logic [DVS_W:0]   diff;
    logic             ge;

    // The compare uses the full shifted width; the subtraction only needs DVS_W+1 bits
    // because a successful trial is always below twice the divisor.
    assign trial = {rem_i, bit_i};
    assign ge    = (trial >= {2'b00, divisor_i});
    assign diff  = trial[DVS_W:0] - {1'b0, divisor_i};
    assign rem_o = ge ? diff : trial[DVS_W:0];
    assign q_o   = ge;

endmodule : div_step

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: DVD_W+1 cycles from accept to done (1 cycle for a zero divisor).
// Accepts start only when ready (IDLE); starts arriving while busy are dropped. DIV_SELFCHECK_EN adds check_err.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int DVD_W = DEF_DVD_W,
    parameter int DVS_W = DEF_DVS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
`ifdef DIV_SELFCHECK_EN
    output logic             div_by_zero,
    output logic             check_err
`else
    output logic             div_by_zero
`endif
);

    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

    state_t           state_q;
    logic [DVD_W-1:0] dvd_q;
    logic [DVS_W-1:0] dvs_q;
    logic [DVS_W:0]   prem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             done_q;
    logic [DVD_W-1:0] quo_q;
    logic [DVS_W-1:0] rem_q;
    logic             dbz_q;

    logic [DVS_W:0]   step_rem_d;
    logic             step_q_d;
    logic [DVD_W-1:0] quo_d;

    div_step #(.DVS_W(DVS_W)) u_div_step (
        .rem_i     (prem_q),
        .bit_i     (dvd_q[DVD_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_d),
        .q_o       (step_q_d)
    );

    // The dividend register doubles as the quotient accumulator: bits leave at the top
    // and quotient bits enter at the bottom.
    assign quo_d = {dvd_q[DVD_W-2:0], step_q_d};

`ifdef DIV_SELFCHECK_EN
    logic [DVD_W-1:0]       dvd_orig_q;
    logic                   chk_q;
    logic [DVD_W+DVS_W-1:0] recon_d;
    logic                   chk_d;

    always_comb begin
        recon_d = (DVD_W+DVS_W)'(quo_d) * (DVD_W+DVS_W)'(dvs_q)
                + (DVD_W+DVS_W)'(step_rem_d[DVS_W-1:0]);
        chk_d   = (recon_d != (DVD_W+DVS_W)'(dvd_orig_q))
                || (step_rem_d[DVS_W-1:0] >= dvs_q);
    end

    assign check_err = chk_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SELFCHECK_EN
            dvd_orig_q <= '0;
            chk_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q   <= dividend;
                        dvs_q   <= divisor;
                        prem_q  <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
`ifdef DIV_SELFCHECK_EN
                        dvd_orig_q <= dividend;
`endif
                        if (divisor == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quo_q   <= '1;
                            rem_q   <= dividend[DVS_W-1:0];
                            dbz_q   <= 1'b1;
`ifdef DIV_SELFCHECK_EN
                            chk_q   <= 1'b0;
`endif
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem_q <= step_rem_d;
                    dvd_q  <= quo_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        quo_q   <= quo_d;
                        rem_q   <= step_rem_d[DVS_W-1:0];
                        dbz_q   <= 1'b0;
`ifdef DIV_SELFCHECK_EN
                        chk_q   <= chk_d;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive checks of restoring_divider at default widths (8/4).
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       ready;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
`ifdef DIV_SELFCHECK_EN
    logic       check_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    restoring_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
`ifdef DIV_SELFCHECK_EN
        .div_by_zero (div_by_zero),
        .check_err   (check_err)
`else
        .div_by_zero (div_by_zero)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 30) begin
            tick();
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    // Presents operands for exactly one accepting edge; returns 1ns after that edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                          input string tag, output int lat);
        wait_ready();
        issue(a, b);
        wait_done(lat);
        check({tag, "_q"},   32'(quotient),    32'(eq));
        check({tag, "_r"},   32'(remainder),   32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
`ifdef DIV_SELFCHECK_EN
        check({tag, "_chk"}, 32'(check_err), 32'd0);
`endif
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) n++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        logic [7:0] mq;
        logic [3:0] mr;
        logic       mz;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done",  32'(done), 32'd0);
        check("rst_q",     32'(quotient), 32'd0);
        check("rst_r",     32'(remainder), 32'd0);
        check("rst_dbz",   32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        // 200/13: done visible just after the 8th calculation edge.
        run_op(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, "d200_13", lat);
        check("d200_13_lat",   32'(lat), 32'd8);
        check("d200_13_rdy",   32'(ready), 32'd0);
        tick();
        check("d200_13_pulse", 32'(done), 32'd0);
        check("d200_13_idle",  32'(ready), 32'd1);
        tick();
        check("d200_13_hold",  32'(quotient), 32'd15);

        run_op(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, "d255_1", lat);
        run_op(8'd7,   4'd15, 8'd0,   4'd7, 1'b0, "d7_15",  lat);

        // Zero divisor: done right after the accepting edge.
        run_op(8'd100, 4'd0, 8'hFF, 4'd4, 1'b1, "d100_0", lat);
        check("d100_0_lat", 32'(lat), 32'd0);

        // A start pulse at E3 carrying 9/2 must not disturb 200/13.
        wait_ready();
        issue(8'd200, 4'd13);
        tick();
        tick();
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd2;
        tick();
        start    = 1'b0;
        wait_done(lat);
        check("ign_lat", 32'(lat), 32'd5);
        check("ign_q",   32'(quotient), 32'd15);
        check("ign_r",   32'(remainder), 32'd5);
        count_done(12, ndone);
        check("ign_no_extra_done", 32'(ndone), 32'd0);

        // Reset at E4 of an operation.
        wait_ready();
        issue(8'd200, 4'd13);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_done",  32'(done), 32'd0);
        check("mid_rst_q",     32'(quotient), 32'd0);
        check("mid_rst_r",     32'(remainder), 32'd0);
        check("mid_rst_dbz",   32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        count_done(12, ndone);
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        run_op(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, "d9_2", lat);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    mq = 8'hFF;
                    mr = 4'(a);
                    mz = 1'b1;
                end else begin
                    mq = 8'(a / b);
                    mr = 4'(a % b);
                    mz = 1'b0;
                end
                run_op(8'(a), 4'(b), mq, mr, mz, $sformatf("sw_%0d_%0d", a, b), lat);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_restoring_divider
